// File: rtl/fft16_bfly_sequencer.sv
// 16-point radix-2 DIT FFT sequencer: buffers a frame, schedules 32 in-place butterflies on an
// external butterfly unit, then streams the spectrum. Optional build macro: FFT_SEQ_SCALE_EN.
module fft16_bfly_sequencer #(
    parameter int BF_LAT = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic [31:0] bf_A,
    output logic [31:0] bf_B,
    output logic [31:0] bf_w,
    input  logic [31:0] bf_Y,
    input  logic [31:0] bf_Z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy
);

    // state    | meaning
    // S_LOAD   | accept 16 samples into mem in bit-reversed order
    // S_CALC   | operands presented to the butterfly, wait BF_LAT+1 cycles
    // S_WB     | write Y/Z back in place, pick next butterfly or finish
    // S_UNLOAD | stream mem[0..15] to the consumer
    typedef enum logic [1:0] {
        S_LOAD,
        S_CALC,
        S_WB,
        S_UNLOAD
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(BF_LAT);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] mem [16];
    logic [3:0]  cnt;
    logic [1:0]  stg;
    logic [2:0]  bfly;
    logic [3:0]  wait_cnt;

    logic        in_xfer;
    logic        load_done;
    logic        last_bfly;
    logic        last_stage;
    logic        calc_entry;
    logic [1:0]  op_stg;
    logic [2:0]  op_bfly;
    logic [3:0]  op_a;
    logic [3:0]  op_b;
    logic [2:0]  op_k;
    logic [3:0]  cur_a;
    logic [3:0]  cur_b;
    logic [31:0] wb_y;
    logic [31:0] wb_z;

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // Top-leg address: group base (b >> s) spaced 2^(s+1) apart, plus offset j within the group.
    function automatic logic [3:0] addr_a(input logic [1:0] st, input logic [2:0] bi);
        logic [2:0] j;
        logic [3:0] grp;
        j   = bi & ((3'd1 << st) - 3'd1);
        grp = {1'b0, bi} >> st;
        return (grp << (3'(st) + 3'd1)) + {1'b0, j};
    endfunction

    function automatic logic [3:0] addr_b(input logic [1:0] st, input logic [2:0] bi);
        return addr_a(st, bi) + (4'd1 << st);
    endfunction

    function automatic logic [2:0] tw_k(input logic [1:0] st, input logic [2:0] bi);
        logic [2:0] j;
        j = bi & ((3'd1 << st) - 3'd1);
        return j << (2'd3 - st);
    endfunction

    // W16^k = {cos, -sin} in Q6.10
    function automatic logic [31:0] tw_rom(input logic [2:0] k);
        logic [31:0] w;
        case (k)
            3'd0:    w = 32'h0400_0000;
            3'd1:    w = 32'h03B2_FE78;
            3'd2:    w = 32'h02D4_FD2C;
            3'd3:    w = 32'h0188_FC4E;
            3'd4:    w = 32'h0000_FC00;
            3'd5:    w = 32'hFE78_FC4E;
            3'd6:    w = 32'hFD2C_FD2C;
            default: w = 32'hFC4E_FE78;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] wb_scale(input logic [31:0] v);
`ifdef FFT_SEQ_SCALE_EN
        return {v[31], v[31:17], v[15], v[15:1]};
`else
        return v;
`endif
    endfunction

    assign in_xfer    = in_valid && in_ready;
    assign load_done  = in_xfer && (cnt == 4'd15);
    assign last_bfly  = (bfly == 3'd7);
    assign last_stage = (stg == 2'd3);
    assign calc_entry = (state_nxt == S_CALC) && (state != S_CALC);
    assign cur_a      = addr_a(stg, bfly);
    assign cur_b      = addr_b(stg, bfly);
    assign op_a       = addr_a(op_stg, op_bfly);
    assign op_b       = addr_b(op_stg, op_bfly);
    assign op_k       = tw_k(op_stg, op_bfly);
    assign wb_y       = wb_scale(bf_Y);
    assign wb_z       = wb_scale(bf_Z);

    // Butterfly about to be entered: first of the frame from LOAD, successor from WB.
    always_comb begin
        op_stg  = 2'd0;
        op_bfly = 3'd0;
        if (state == S_WB) begin
            if (!last_bfly) begin
                op_stg  = stg;
                op_bfly = bfly + 3'd1;
            end else begin
                op_stg  = stg + 2'd1;
                op_bfly = 3'd0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: begin
                if (load_done) state_nxt = S_CALC;
            end
            S_CALC: begin
                if (wait_cnt == 4'd0) state_nxt = S_WB;
            end
            S_WB: begin
                state_nxt = (last_bfly && last_stage) ? S_UNLOAD : S_CALC;
            end
            S_UNLOAD: begin
                if (out_ready && (cnt == 4'd15)) state_nxt = S_LOAD;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (state)
            S_LOAD: in_ready = 1'b1;
            S_CALC, S_WB: busy = 1'b1;
            S_UNLOAD: begin
                out_valid = 1'b1;
                out_data  = mem[cnt];
                out_last  = (cnt == 4'd15);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt      <= '0;
            stg      <= '0;
            bfly     <= '0;
            wait_cnt <= '0;
            bf_A     <= '0;
            bf_B     <= '0;
            bf_w     <= '0;
        end else begin
            if (calc_entry) begin
                stg      <= op_stg;
                bfly     <= op_bfly;
                wait_cnt <= WAIT_INIT;
                bf_A     <= mem[op_a];
                bf_B     <= mem[op_b];
                bf_w     <= tw_rom(op_k);
            end else if ((state == S_CALC) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            // cnt wraps 15 -> 0 on the last load/unload transfer
            case (state)
                S_LOAD: begin
                    if (in_xfer) cnt <= cnt + 4'd1;
                end
                S_WB: begin
                    if (last_bfly && last_stage) cnt <= '0;
                end
                S_UNLOAD: begin
                    if (out_ready) cnt <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Sample memory is deliberately not reset; a new frame overwrites all 16 entries.
    // In-place indices of consecutive butterflies never overlap, so no write forwarding.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            if (in_xfer) begin
                mem[bitrev4(cnt)] <= in_data;
            end else if (state == S_WB) begin
                mem[cur_a] <= wb_y;
                mem[cur_b] <= wb_z;
            end
        end
    end

endmodule
